// File: rtl/neuron_pkg.sv
// neuron_pkg: shared defaults, output polarity encoding and a counter-width
// helper for the integrate-and-fire neuron slice.
//   DEF_*       : default parameter values used by neuron and neuron_sat_add
//   polarity_e  : output spike polarity (POS = 0, NEG = 1)
//   cnt_width() : bits needed to hold a count of 0..max_val (at least 1)
package neuron_pkg;

   localparam int DEF_WEIGHT_W    = 4;
   localparam int DEF_POT_W       = 8;
   localparam int DEF_THRESH      = 4;
   localparam int DEF_LEAK_PERIOD = 0;
   localparam int DEF_REFRACT     = 0;

   typedef enum logic {
      POS = 1'b0,
      NEG = 1'b1
   } polarity_e;

   function automatic int cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/neuron_sat_add.sv
// neuron_sat_add: combinational update of the signed membrane potential.
//   pot    : current potential, signed POT_W bits
//   weight : unsigned synaptic magnitude, zero-extended
//   neg    : 1 = subtract weight, 0 = add weight
//   step   : 1 = ignore weight and move pot one step toward zero
//   result : saturated signed POT_W-bit result
module neuron_sat_add
   import neuron_pkg::*;
#(
   parameter int POT_W    = DEF_POT_W,
   parameter int WEIGHT_W = DEF_WEIGHT_W
) (
   input  logic signed [POT_W-1:0]    pot,
   input  logic        [WEIGHT_W-1:0] weight,
   input  logic                       neg,
   input  logic                       step,
   output logic signed [POT_W-1:0]    result
);

   // Two guard bits over the wider operand so pot +/- weight never wraps
   // before the clamp is applied.
   localparam int EXT_W = ((POT_W > WEIGHT_W) ? POT_W : WEIGHT_W) + 2;

   localparam logic signed [EXT_W-1:0] MAX_X =
      {{(EXT_W-POT_W+1){1'b0}}, {(POT_W-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] MIN_X = ~MAX_X;

   logic signed [EXT_W-1:0] pot_x;
   logic signed [EXT_W-1:0] w_x;
   logic signed [EXT_W-1:0] sum_x;

   assign pot_x = {{(EXT_W-POT_W){pot[POT_W-1]}}, pot};
   assign w_x   = {{(EXT_W-WEIGHT_W){1'b0}}, weight};

   always_comb begin
      sum_x  = '0;
      result = pot;
      if (step) begin
         if (pot == '0) begin
            result = pot;
         end else if (pot[POT_W-1]) begin
            result = pot + POT_W'(1);
         end else begin
            result = pot - POT_W'(1);
         end
      end else begin
         sum_x = neg ? (pot_x - w_x) : (pot_x + w_x);
         if (sum_x > MAX_X) begin
            result = MAX_X[POT_W-1:0];
         end else if (sum_x < MIN_X) begin
            result = MIN_X[POT_W-1:0];
         end else begin
            result = sum_x[POT_W-1:0];
         end
      end
   end

endmodule

// File: rtl/neuron.sv
// neuron: leaky integrate-and-fire neuron with bipolar thresholds,
// optional refractory period and optional leak toward zero.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   weight   : unsigned synaptic magnitude, sampled with data_in
//   data_in  : input spike strobe
//   sign_in  : input polarity (0 = excitatory, 1 = inhibitory)
//   data_out : registered one-cycle output spike
//   sign_out : registered output polarity (0 = positive, 1 = negative)
module neuron
   import neuron_pkg::*;
#(
   parameter int WEIGHT_W    = DEF_WEIGHT_W,
   parameter int POT_W       = DEF_POT_W,
   parameter int THRESH      = DEF_THRESH,
   parameter int LEAK_PERIOD = DEF_LEAK_PERIOD,
   parameter int REFRACT     = DEF_REFRACT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WEIGHT_W-1:0] weight,
   input  logic                data_in,
   input  logic                sign_in,
   output logic                data_out,
   output logic                sign_out
);

   localparam int LEAK_CW = cnt_width(LEAK_PERIOD);
   localparam int REFR_CW = cnt_width(REFRACT);

   localparam logic signed [POT_W-1:0] THR_POS = POT_W'(THRESH);
   localparam logic signed [POT_W-1:0] THR_NEG = -THR_POS;

   logic signed [POT_W-1:0] pot;
   logic signed [POT_W-1:0] pot_nxt;
   logic signed [POT_W-1:0] sat_result;
   logic [LEAK_CW-1:0]      leak_cnt;
   logic [LEAK_CW-1:0]      leak_cnt_nxt;
   logic [REFR_CW-1:0]      refr_cnt;
   logic [REFR_CW-1:0]      refr_cnt_nxt;
   logic                    accept;
   logic                    step_mode;
   logic                    fire;
   polarity_e               fire_pol;

   // Spikes arriving while the refractory counter is running are dropped
   // and treated as idle cycles for the leak counter.
   assign accept    = data_in & (refr_cnt == '0);
   assign step_mode = ~accept;

   // A single adder serves both paths: add/subtract on an accepted spike,
   // step toward zero otherwise (only committed on a leak event).
   neuron_sat_add #(
      .POT_W    (POT_W),
      .WEIGHT_W (WEIGHT_W)
   ) u_sat_add (
      .pot    (pot),
      .weight (weight),
      .neg    (sign_in),
      .step   (step_mode),
      .result (sat_result)
   );

   always_comb begin
      pot_nxt      = pot;
      leak_cnt_nxt = leak_cnt;
      refr_cnt_nxt = refr_cnt;
      fire         = 1'b0;
      fire_pol     = POS;

      if (refr_cnt != '0) begin
         refr_cnt_nxt = refr_cnt - REFR_CW'(1);
      end

      if (accept) begin
         leak_cnt_nxt = '0;
         if (sat_result >= THR_POS) begin
            fire     = 1'b1;
            fire_pol = POS;
            pot_nxt  = '0;
         end else if (sat_result <= THR_NEG) begin
            fire     = 1'b1;
            fire_pol = NEG;
            pot_nxt  = '0;
         end else begin
            pot_nxt = sat_result;
         end
         if (fire) begin
            refr_cnt_nxt = REFR_CW'(REFRACT);
         end
      end else if (LEAK_PERIOD != 0) begin
         if (int'(leak_cnt) + 1 == LEAK_PERIOD) begin
            leak_cnt_nxt = '0;
            pot_nxt      = sat_result;
         end else begin
            leak_cnt_nxt = leak_cnt + LEAK_CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pot      <= '0;
         leak_cnt <= '0;
         refr_cnt <= '0;
         data_out <= 1'b0;
         sign_out <= POS;
      end else begin
         pot      <= pot_nxt;
         leak_cnt <= leak_cnt_nxt;
         refr_cnt <= refr_cnt_nxt;
         data_out <= fire;
         sign_out <= fire_pol;
      end
   end

endmodule

// File: tb/tb_neuron.sv
// tb_neuron: four neuron configurations driven by shared stimulus and
// checked every cycle against an integer reference model, plus a directed
// vector table and hand-written multi-cycle sequences.
module tb_neuron;

   localparam int NCFG = 4;
   localparam int CFG_PW[NCFG] = '{8, 8, 8, 4};
   localparam int CFG_TH[NCFG] = '{4, 4, 4, 7};
   localparam int CFG_LP[NCFG] = '{0, 0, 3, 0};
   localparam int CFG_RF[NCFG] = '{0, 2, 0, 0};

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] weight;
   logic       data_in;
   logic       sign_in;
   logic [3:0] dout;
   logic [3:0] sout;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int pot;
      int leak;
      int refr;
      int out;
      int sgn;
   } mstate_t;

   mstate_t ms[NCFG];

   typedef struct {
      bit       rst;
      bit       din;
      bit       sgn;
      bit [3:0] w;
      int       exp_pot;
      int       exp_out;
      int       exp_sgn;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   neuron #(.WEIGHT_W(4), .POT_W(8), .THRESH(4), .LEAK_PERIOD(0), .REFRACT(0)) u0 (
      .clk(clk), .rst(rst), .weight(weight), .data_in(data_in), .sign_in(sign_in),
      .data_out(dout[0]), .sign_out(sout[0]));
   neuron #(.WEIGHT_W(4), .POT_W(8), .THRESH(4), .LEAK_PERIOD(0), .REFRACT(2)) u1 (
      .clk(clk), .rst(rst), .weight(weight), .data_in(data_in), .sign_in(sign_in),
      .data_out(dout[1]), .sign_out(sout[1]));
   neuron #(.WEIGHT_W(4), .POT_W(8), .THRESH(4), .LEAK_PERIOD(3), .REFRACT(0)) u2 (
      .clk(clk), .rst(rst), .weight(weight), .data_in(data_in), .sign_in(sign_in),
      .data_out(dout[2]), .sign_out(sout[2]));
   neuron #(.WEIGHT_W(4), .POT_W(4), .THRESH(7), .LEAK_PERIOD(0), .REFRACT(0)) u3 (
      .clk(clk), .rst(rst), .weight(weight), .data_in(data_in), .sign_in(sign_in),
      .data_out(dout[3]), .sign_out(sout[3]));

   function automatic int act_pot(input int k);
      case (k)
         0:       return int'(u0.pot);
         1:       return int'(u1.pot);
         2:       return int'(u2.pot);
         default: return int'(u3.pot);
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: integer potential, clamp to the signed range, compare
   // against +/-threshold, count refractory and idle cycles.
   task automatic model_step(input int k, input bit r, input bit d, input bit s, input int w);
      int hi, lo, sum;
      hi = (1 << (CFG_PW[k] - 1)) - 1;
      lo = -hi - 1;
      if (r) begin
         ms[k] = '{0, 0, 0, 0, 0};
         return;
      end
      ms[k].out = 0;
      ms[k].sgn = 0;
      if (d && ms[k].refr == 0) begin
         sum = ms[k].pot + (s ? -w : w);
         if (sum > hi) sum = hi;
         if (sum < lo) sum = lo;
         ms[k].leak = 0;
         if (sum >= CFG_TH[k]) begin
            ms[k].out = 1; ms[k].sgn = 0; ms[k].pot = 0; ms[k].refr = CFG_RF[k];
         end else if (sum <= -CFG_TH[k]) begin
            ms[k].out = 1; ms[k].sgn = 1; ms[k].pot = 0; ms[k].refr = CFG_RF[k];
         end else begin
            ms[k].pot = sum;
         end
      end else begin
         if (ms[k].refr > 0) ms[k].refr--;
         if (CFG_LP[k] > 0) begin
            ms[k].leak++;
            if (ms[k].leak == CFG_LP[k]) begin
               ms[k].leak = 0;
               if (ms[k].pot > 0) ms[k].pot--;
               else if (ms[k].pot < 0) ms[k].pot++;
            end
         end
      end
   endtask

   task automatic cycle(input bit r, input bit d, input bit s, input bit [3:0] w);
      rst = r; data_in = d; sign_in = s; weight = w;
      @(posedge clk);
      for (int k = 0; k < NCFG; k++) model_step(k, r, d, s, int'(w));
      #1;
      for (int k = 0; k < NCFG; k++) begin
         check($sformatf("u%0d_pot", k), act_pot(k), ms[k].pot);
         check($sformatf("u%0d_data_out", k), int'(dout[k]), ms[k].out);
         check($sformatf("u%0d_sign_out", k), int'(sout[k]), ms[k].sgn);
      end
   endtask

   task automatic spike(input bit s, input bit [3:0] w);
      cycle(1'b0, 1'b1, s, w);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, 4'd0);
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, 1'b0, 4'd0);
   endtask

   initial begin
      rst = 1'b1; data_in = 1'b0; sign_in = 1'b0; weight = '0;

      // Default configuration: reset, four +1, four -1, alternating run.
      vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd5,  0, 0, 0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd1,  1, 0, 0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd1,  2, 0, 0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd1,  3, 0, 0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd1,  0, 1, 0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd1,  0, 0, 0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd1, -1, 0, 0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd1, -2, 0, 0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd1, -3, 0, 0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd1,  0, 1, 1});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd1, -1, 0, 0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd1,  0, 0, 0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd1, -1, 0, 0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd1, -2, 0, 0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd1, -1, 0, 0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd1, -2, 0, 0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd1, -3, 0, 0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd1, -3, 0, 0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd0, -3, 0, 0});

      for (int i = 0; i < vecs.size(); i++) begin
         cycle(vecs[i].rst, vecs[i].din, vecs[i].sgn, vecs[i].w);
         check($sformatf("tbl%0d_pot", i), act_pot(0), vecs[i].exp_pot);
         check($sformatf("tbl%0d_out", i), int'(dout[0]), vecs[i].exp_out);
         check($sformatf("tbl%0d_sgn", i), int'(sout[0]), vecs[i].exp_sgn);
      end

      // Refractory: fire, two discarded spikes, third accepted.
      do_reset();
      repeat (4) spike(1'b0, 4'd1);
      check("refr_fire", int'(dout[1]), 1);
      spike(1'b0, 4'd1);
      check("refr_drop1_pot", act_pot(1), 0);
      check("refr_drop1_out", int'(dout[1]), 0);
      spike(1'b0, 4'd1);
      check("refr_drop2_pot", act_pot(1), 0);
      spike(1'b0, 4'd1);
      check("refr_accept_pot", act_pot(1), 1);

      // Reset mid-refractory: first spike after reset is accepted.
      do_reset();
      repeat (4) spike(1'b0, 4'd1);
      cycle(1'b1, 1'b1, 1'b0, 4'd3);
      check("rst_refr_pot", act_pot(1), 0);
      spike(1'b0, 4'd1);
      check("post_rst_refr_pot", act_pot(1), 1);

      // Leak: pot 3, three idles -> 2, six more -> 0, then holds.
      do_reset();
      repeat (3) spike(1'b0, 4'd1);
      check("leak_start", act_pot(2), 3);
      idle(); idle();
      check("leak_before_step", act_pot(2), 3);
      idle();
      check("leak_step1", act_pot(2), 2);
      repeat (6) idle();
      check("leak_zero", act_pot(2), 0);
      repeat (4) idle();
      check("leak_hold", act_pot(2), 0);
      spike(1'b0, 4'd0);
      idle(); idle();
      check("leak_w0_clears", act_pot(2), 0);

      // Narrow potential: weight 15 saturates to 7 and fires; reset mid-run.
      do_reset();
      spike(1'b0, 4'd15);
      check("sat_fire_out", int'(dout[3]), 1);
      check("sat_fire_sgn", int'(sout[3]), 0);
      check("sat_fire_pot", act_pot(3), 0);
      spike(1'b0, 4'd5);
      check("sat_mid_pot", act_pot(3), 5);
      cycle(1'b1, 1'b1, 1'b0, 4'd5);
      check("sat_rst_pot", act_pot(3), 0);
      check("sat_rst_out", int'(dout[3]), 0);
      spike(1'b1, 4'd15);
      check("sat_neg_out", int'(dout[3]), 1);
      check("sat_neg_sgn", int'(sout[3]), 1);

      // Randomized stimulus against the reference model.
      for (int n = 0; n < 600; n++) begin
         bit       r, d, s;
         bit [3:0] w;
         r = ($urandom_range(0, 59) == 0);
         d = ($urandom_range(0, 9) < 4);
         s = 1'($urandom_range(0, 1));
         w = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
         cycle(r, d, s, w);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
